// File: rtl/alu_issue_sequencer.sv
// Sequences requests from two requesters onto the shared ALU.
// Define ALU_SEQ_FIXED_PRIO_EN to make requester 0 always win a tie.
module alu_issue_sequencer #(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int CNT_W          = 8
) (
  input  logic        soc_clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_dat1,
  input  logic [31:0] req0_dat2,
  input  logic [4:0]  req0_instr,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_dat1,
  input  logic [31:0] req1_dat2,
  input  logic [4:0]  req1_instr,
  output logic        rsp0_valid,
  output logic        rsp1_valid,
  output logic [31:0] rsp_out,
  output logic        rsp_overflow,
  output logic        rsp_con_met,
  output logic        rsp_zero,
  output logic        rsp_err,
  output logic        alu_dat_ready,
  output logic [31:0] alu_dat1,
  output logic [31:0] alu_dat2,
  output logic [4:0]  alu_instr,
  input  logic [31:0] alu_out,
  input  logic        alu_overflow,
  input  logic        alu_con_met,
  input  logic        alu_zero,
  input  logic        alu_ready
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SETUP   = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_RESP    = 3'd3;
  localparam logic [2:0] S_RECOVER = 3'd4;

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             owner_q, owner_d;
  logic             gnt;
  logic             gnt_id;
  logic             tie_pick;
  logic [31:0]      g_dat1, g_dat2;
  logic [4:0]       g_instr;
  logic             g_illegal;

  logic        req0_ready_q, req1_ready_q;
  logic        rsp0_valid_q, rsp1_valid_q;
  logic [31:0] rsp_out_q;
  logic        rsp_ov_q, rsp_cm_q, rsp_zero_q, rsp_err_q;
  logic        dat_ready_q;
  logic [31:0] alu_dat1_q, alu_dat2_q;
  logic [4:0]  alu_instr_q;

`ifdef ALU_SEQ_FIXED_PRIO_EN
  assign tie_pick = 1'b0;
`else
  logic rr_last_q;

  // Remember the last granted requester for round-robin ties
  always_ff @(posedge soc_clk or posedge reset) begin
    if (reset) begin
      rr_last_q <= 1'b1;
    end else if (gnt) begin
      rr_last_q <= gnt_id;
    end
  end

  assign tie_pick = ~rr_last_q;
`endif

  // Pick which requester would be granted this cycle
  always_comb begin
    gnt_id = 1'b0;
    unique case (1'b1)
      req0_valid && req1_valid:  gnt_id = tie_pick;
      !req0_valid && req1_valid: gnt_id = 1'b1;
      default:                   gnt_id = 1'b0;
    endcase
  end

  assign g_dat1    = gnt_id ? req1_dat1 : req0_dat1;
  assign g_dat2    = gnt_id ? req1_dat2 : req0_dat2;
  assign g_instr   = gnt_id ? req1_instr : req0_instr;
  assign g_illegal = g_instr > 5'd15;

  // Next-state logic for the issue FSM and timeout counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    gnt     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req0_valid || req1_valid) begin
          gnt     = 1'b1;
          owner_d = gnt_id;
          state_d = g_illegal ? S_RESP : S_SETUP;
        end
      end
      S_SETUP: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (alu_ready || cnt_q == TO_LAST) begin
          state_d = S_RESP;
        end
      end
      S_RESP: state_d = S_RECOVER;
      S_RECOVER: begin
        if (!alu_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, owner and counter registers
  always_ff @(posedge soc_clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      owner_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
    end
  end

  // Registered handshake, ALU drive and response outputs
  always_ff @(posedge soc_clk or posedge reset) begin
    if (reset) begin
      req0_ready_q <= 1'b0;
      req1_ready_q <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp_out_q    <= '0;
      rsp_ov_q     <= 1'b0;
      rsp_cm_q     <= 1'b0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
      dat_ready_q  <= 1'b0;
      alu_dat1_q   <= '0;
      alu_dat2_q   <= '0;
      alu_instr_q  <= '0;
    end else begin
      req0_ready_q <= gnt && !gnt_id;
      req1_ready_q <= gnt && gnt_id;
      if (gnt && !g_illegal) begin
        alu_dat1_q  <= g_dat1;
        alu_dat2_q  <= g_dat2;
        alu_instr_q <= g_instr;
      end
      dat_ready_q  <= state_d == S_WAIT;
      rsp0_valid_q <= state_d == S_RESP && !owner_d;
      rsp1_valid_q <= state_d == S_RESP && owner_d;
      if (state_d == S_RESP) begin
        if (state_q == S_WAIT && alu_ready) begin
          rsp_out_q  <= alu_out;
          rsp_ov_q   <= alu_overflow;
          rsp_cm_q   <= alu_con_met;
          rsp_zero_q <= alu_zero;
          rsp_err_q  <= 1'b0;
        end else begin
          rsp_out_q  <= '0;
          rsp_ov_q   <= 1'b0;
          rsp_cm_q   <= 1'b0;
          rsp_zero_q <= 1'b0;
          rsp_err_q  <= 1'b1;
        end
      end
    end
  end

  assign req0_ready    = req0_ready_q;
  assign req1_ready    = req1_ready_q;
  assign rsp0_valid    = rsp0_valid_q;
  assign rsp1_valid    = rsp1_valid_q;
  assign rsp_out       = rsp_out_q;
  assign rsp_overflow  = rsp_ov_q;
  assign rsp_con_met   = rsp_cm_q;
  assign rsp_zero      = rsp_zero_q;
  assign rsp_err       = rsp_err_q;
  assign alu_dat_ready = dat_ready_q;
  assign alu_dat1      = alu_dat1_q;
  assign alu_dat2      = alu_dat2_q;
  assign alu_instr     = alu_instr_q;

endmodule

// File: tb/tb_alu_issue_sequencer.sv
// Scoreboard bench for alu_issue_sequencer with a 3-count ALU stub.
// Honors ALU_SEQ_FIXED_PRIO_EN for the expected grant order.
module tb_alu_issue_sequencer;

  localparam int TO = 15;

  logic        soc_clk, reset;
  logic        req0_valid, req0_ready;
  logic [31:0] req0_dat1, req0_dat2;
  logic [4:0]  req0_instr;
  logic        req1_valid, req1_ready;
  logic [31:0] req1_dat1, req1_dat2;
  logic [4:0]  req1_instr;
  logic        rsp0_valid, rsp1_valid;
  logic [31:0] rsp_out;
  logic        rsp_overflow, rsp_con_met, rsp_zero, rsp_err;
  logic        alu_dat_ready;
  logic [31:0] alu_dat1, alu_dat2;
  logic [4:0]  alu_instr;
  logic [31:0] alu_out;
  logic        alu_overflow, alu_con_met, alu_zero, alu_ready;

  int          n_chk, n_fail, cyc;
  logic [35:0] q0[$];
  logic [35:0] q1[$];
  int          grant_log[$];
  int          rises, hi_run, last_hi, rsp_cnt;
  int          last_gnt_cyc, last_rsp_cyc, fall_cyc;
  logic        prev_dr, prev_ar;
  logic [68:0] prev_ops;
  logic        stuck;
  int          hold_extra, hold_cnt, busy;
  logic [35:0] stub_res;

  alu_issue_sequencer #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .soc_clk(soc_clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_dat1(req0_dat1), .req0_dat2(req0_dat2),
    .req0_instr(req0_instr),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_dat1(req1_dat1), .req1_dat2(req1_dat2),
    .req1_instr(req1_instr),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp_out(rsp_out), .rsp_overflow(rsp_overflow),
    .rsp_con_met(rsp_con_met), .rsp_zero(rsp_zero),
    .rsp_err(rsp_err), .alu_dat_ready(alu_dat_ready),
    .alu_dat1(alu_dat1), .alu_dat2(alu_dat2),
    .alu_instr(alu_instr), .alu_out(alu_out),
    .alu_overflow(alu_overflow), .alu_con_met(alu_con_met),
    .alu_zero(alu_zero), .alu_ready(alu_ready)
  );

  initial soc_clk = 1'b0;
  always #5 soc_clk = ~soc_clk;

  task automatic check(input string tag, input logic [71:0] got,
                       input logic [71:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference ALU: {err, overflow, con_met, zero, out}
  function automatic logic [35:0] alu_fn(input logic [4:0] ins,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    logic [31:0] r;
    logic        ov, cm;
    ov = 1'b0;
    cm = 1'b0;
    case (ins)
      5'd0: begin r = a - b; cm = (a == b); end
      5'd6: begin
        r  = a + b;
        ov = (a[31] == b[31]) && (r[31] != a[31]);
      end
      5'd11: r = a ^ b;
      default: r = a & b;
    endcase
    return {1'b0, ov, cm, (r == 32'd0), r};
  endfunction

  initial stub_res = '0;
  always @(posedge alu_dat_ready)
    stub_res = alu_fn(alu_instr, alu_dat1, alu_dat2);
  assign {alu_overflow, alu_con_met, alu_zero, alu_out} = stub_res[34:0];

  always @(posedge soc_clk) begin
    if (reset) begin
      busy <= 0;
      hold_cnt <= 0;
      alu_ready <= 1'b0;
    end else if (alu_dat_ready) begin
      hold_cnt <= hold_extra;
      if (!stuck) begin
        if (busy < 3) busy <= busy + 1;
        else alu_ready <= 1'b1;
      end
    end else begin
      busy <= 0;
      if (alu_ready && hold_cnt != 0) hold_cnt <= hold_cnt - 1;
      else alu_ready <= 1'b0;
    end
  end

  always @(negedge soc_clk) begin
    logic [35:0] e;
    cyc++;
    if (req0_ready) begin grant_log.push_back(0); last_gnt_cyc = cyc; end
    if (req1_ready) begin grant_log.push_back(1); last_gnt_cyc = cyc; end
    if (rsp0_valid) begin
      rsp_cnt++;
      last_rsp_cyc = cyc;
      check("rsp0_pending", 72'(q0.size() != 0), 72'd1);
      if (q0.size() != 0) begin
        e = q0.pop_front();
        check("rsp0_data", 72'({rsp_err, rsp_overflow, rsp_con_met,
                                rsp_zero, rsp_out}), 72'(e));
      end
    end
    if (rsp1_valid) begin
      rsp_cnt++;
      last_rsp_cyc = cyc;
      check("rsp1_pending", 72'(q1.size() != 0), 72'd1);
      if (q1.size() != 0) begin
        e = q1.pop_front();
        check("rsp1_data", 72'({rsp_err, rsp_overflow, rsp_con_met,
                                rsp_zero, rsp_out}), 72'(e));
      end
    end
    if (alu_dat_ready && !prev_dr) begin
      rises++;
      check("ops_stable", 72'({alu_dat1, alu_dat2, alu_instr}),
            72'(prev_ops));
    end
    if (alu_dat_ready) hi_run++;
    else if (prev_dr) begin last_hi = hi_run; hi_run = 0; end
    if (!alu_ready && prev_ar) fall_cyc = cyc;
    prev_dr  = alu_dat_ready;
    prev_ar  = alu_ready;
    prev_ops = {alu_dat1, alu_dat2, alu_instr};
  end

  task automatic drive(input int who, input logic [4:0] ins,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [35:0] exp);
    int n;
    n = 0;
    if (who == 0) begin
      req0_valid = 1'b1; req0_instr = ins;
      req0_dat1 = a; req0_dat2 = b;
      q0.push_back(exp);
    end else begin
      req1_valid = 1'b1; req1_instr = ins;
      req1_dat1 = a; req1_dat2 = b;
      q1.push_back(exp);
    end
    do begin
      @(negedge soc_clk);
      n++;
    end while (!(who == 0 ? req0_ready : req1_ready) && n < 300);
    check($sformatf("grant_wait%0d", who), 72'(n >= 300), 72'd0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 400) begin
      @(negedge soc_clk);
      n++;
    end
    check("drain", 72'(n >= 400), 72'd0);
    repeat (3) @(negedge soc_clk);
  endtask

  task automatic do_reset();
    @(negedge soc_clk);
    reset = 1'b1;
    repeat (2) @(negedge soc_clk);
    reset = 1'b0;
    @(negedge soc_clk);
  endtask

  initial begin
    int          r0, c, n;
    logic [31:0] save;
    logic [5:0]  order, exp_order;
    reset = 1'b1;
    req0_valid = 0; req0_dat1 = 0; req0_dat2 = 0; req0_instr = 0;
    req1_valid = 0; req1_dat1 = 0; req1_dat2 = 0; req1_instr = 0;
    stuck = 0; hold_extra = 0;
    n_chk = 0; n_fail = 0; cyc = 0; rises = 0; hi_run = 0;
    last_hi = 0; rsp_cnt = 0; last_gnt_cyc = 0; last_rsp_cyc = 0;
    fall_cyc = 0; prev_dr = 0; prev_ar = 0; prev_ops = '0;
    repeat (3) @(negedge soc_clk);
    check("reset_ctl", 72'({req0_ready, req1_ready, rsp0_valid,
          rsp1_valid, rsp_out, rsp_overflow, rsp_con_met, rsp_zero,
          rsp_err, alu_dat_ready}), 72'd0);
    check("reset_ops", 72'({alu_dat1, alu_dat2, alu_instr}), 72'd0);
    reset = 1'b0;
    @(negedge soc_clk);

    drive(0, 5'd6, 32'h7FFF_FFFF, 32'd1,
          alu_fn(5'd6, 32'h7FFF_FFFF, 32'd1));
    req0_valid = 1'b0;
    drain();
    check("add_rsp", 72'({rsp_err, rsp_overflow, rsp_out}),
          72'({1'b0, 1'b1, 32'h8000_0000}));
    check("add_issue_count", 72'(rises), 72'd1);

    do_reset();
    grant_log.delete();
    fork
      begin
        for (int i = 0; i < 3; i++)
          drive(0, 5'd6, 32'(i * 100 + 1), 32'd7,
                alu_fn(5'd6, 32'(i * 100 + 1), 32'd7));
        req0_valid = 1'b0;
      end
      begin
        for (int j = 0; j < 3; j++)
          drive(1, 5'd0, 32'd5, 32'd5, alu_fn(5'd0, 32'd5, 32'd5));
        req1_valid = 1'b0;
      end
    join
    drain();
    check("grant_count", 72'(grant_log.size()), 72'd6);
    order = '0;
    for (int k = 0; k < 6 && k < grant_log.size(); k++)
      order[5-k] = grant_log[k][0];
`ifdef ALU_SEQ_FIXED_PRIO_EN
    exp_order = 6'b000111;
`else
    exp_order = 6'b010101;
`endif
    check("grant_order", 72'(order), 72'(exp_order));
    check("beq_con_met", 72'({rsp_con_met, rsp_err}), 72'(2'b10));

    @(negedge soc_clk);
    save = alu_dat1;
    r0 = rises;
    drive(1, 5'd16, 32'h1234, 32'h5678, 36'h8_0000_0000);
    req1_valid = 1'b0;
    drain();
    check("illegal_no_issue", 72'(rises), 72'(r0));
    check("illegal_latency",
          72'(last_rsp_cyc - last_gnt_cyc <= 1), 72'd1);
    check("illegal_rsp", 72'({rsp_err, rsp_out}), 72'({1'b1, 32'd0}));
    check("ops_hold", 72'(alu_dat1), 72'(save));

    stuck = 1'b1;
    drive(0, 5'd6, 32'd3, 32'd4, 36'h8_0000_0000);
    req0_valid = 1'b0;
    drain();
    check("timeout_len", 72'(last_hi), 72'(TO));
    check("timeout_err", 72'(rsp_err), 72'd1);
    stuck = 1'b0;
    drive(0, 5'd11, 32'hAAAA_0000, 32'h0000_AAAA,
          alu_fn(5'd11, 32'hAAAA_0000, 32'h0000_AAAA));
    req0_valid = 1'b0;
    drain();
    check("post_timeout", 72'({rsp_err, rsp_out}),
          72'({1'b0, 32'hAAAA_AAAA}));

    hold_extra = 3;
    drive(0, 5'd6, 32'd10, 32'd20, alu_fn(5'd6, 32'd10, 32'd20));
    drive(0, 5'd6, 32'd1, 32'd2, alu_fn(5'd6, 32'd1, 32'd2));
    req0_valid = 1'b0;
    #1;
    check("recover_gate", 72'(last_gnt_cyc > fall_cyc), 72'd1);
    drain();
    hold_extra = 0;
    repeat (6) @(negedge soc_clk);

    drive(0, 5'd6, 32'd1, 32'd1, alu_fn(5'd6, 32'd1, 32'd1));
    req0_valid = 1'b0;
    n = 0;
    while (!alu_dat_ready && n < 50) begin
      @(negedge soc_clk);
      n++;
    end
    check("reach_wait", 72'(n >= 50), 72'd0);
    @(negedge soc_clk);
    check("in_wait", 72'(alu_dat_ready), 72'd1);
    #2;
    reset = 1'b1;
    #1;
    check("async_drop", 72'(alu_dat_ready), 72'd0);
    q0.delete();
    c = rsp_cnt;
    repeat (3) @(negedge soc_clk);
    reset = 1'b0;
    repeat (10) @(negedge soc_clk);
    check("no_rsp_abort", 72'(rsp_cnt), 72'(c));
    drive(0, 5'd11, 32'hF0F0_F0F0, 32'h0F0F_0F0F,
          alu_fn(5'd11, 32'hF0F0_F0F0, 32'h0F0F_0F0F));
    req0_valid = 1'b0;
    drain();
    check("xor_rsp", 72'({rsp_err, rsp_out}), 72'({1'b0, 32'hFFFF_FFFF}));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
